// File: rtl/seq_subtractor_64bit_pkg.sv
// Shared constants and FSM encoding for the byte-serial 64-bit subtractor.
package seq_subtractor_64bit_pkg;
   localparam int WIDTH  = 64;
   localparam int SLICE  = 8;
   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDX_W  = $clog2(NSLICE);
   localparam int SEL_W  = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit offset of byte slice idx within the 64-bit word.
   function automatic logic [SEL_W-1:0] slice_lsb(input logic [IDX_W-1:0] idx);
      return {idx, 3'b000};
   endfunction
endpackage

// File: rtl/seq_subtractor_64bit_sub.sv
// 8-bit ripple-borrow subtractor: d = a - b - bin, bout set on underflow.
module ripple_sub_8bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       bin,
   output logic [7:0] d,
   output logic       bout
);
   logic [8:0] w_brw;

   assign w_brw[0] = bin;

   for (genvar i = 0; i < 8; i++) begin : g_fs
      logic w_x;
      assign w_x          = a[i] ^ b[i];
      assign d[i]         = w_x ^ w_brw[i];
      assign w_brw[i+1]   = (~a[i] & b[i]) | (~w_x & w_brw[i]);
   end

   assign bout = w_brw[8];
endmodule

// File: rtl/seq_subtractor_64bit.sv
// Byte-serial 64-bit subtractor: one 8-bit slice per clock, borrow carried in a register.
module seq_subtractor_64bit
   import seq_subtractor_64bit_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow,
   output logic             busy,
   output logic             done
);
   state_t           r_state;
   logic [IDX_W-1:0] r_idx;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_bin;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;
   logic             r_ovf;
   logic             r_busy;
   logic             r_done;

   logic [SEL_W-1:0] w_sel;
   logic [SLICE-1:0] w_a_byte;
   logic [SLICE-1:0] w_b_byte;
   logic [SLICE-1:0] w_d;
   logic             w_bout;
   logic             w_accept;
   logic             w_last;

   assign w_sel    = slice_lsb(r_idx);
   assign w_a_byte = r_a[w_sel +: SLICE];
   assign w_b_byte = r_b[w_sel +: SLICE];
   // start is only honoured when no subtraction is in flight
   assign w_accept = start && (r_state != RUN);
   assign w_last   = (r_idx == IDX_W'(NSLICE - 1));

   ripple_sub_8bit u_slice (
      .a    (w_a_byte),
      .b    (w_b_byte),
      .bin  (r_bin),
      .d    (w_d),
      .bout (w_bout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_idx    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_bin    <= 1'b0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_ovf    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else if (w_accept) begin
         r_state  <= RUN;
         r_idx    <= '0;
         r_a      <= A;
         r_b      <= B;
         r_bin    <= 1'b0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_ovf    <= 1'b0;
         r_busy   <= 1'b1;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               r_diff[w_sel +: SLICE] <= w_d;
               r_bin                  <= w_bout;
               r_idx                  <= r_idx + IDX_W'(1);
               if (w_last) begin
                  // Final slice: w_d[7] is the result MSB being written this edge.
                  r_state  <= DONE;
                  r_borrow <= w_bout;
                  r_ovf    <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_d[SLICE-1] ^ r_a[WIDTH-1]);
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign diff     = r_diff;
   assign borrow   = r_borrow;
   assign overflow = r_ovf;
   assign busy     = r_busy;
   assign done     = r_done;
endmodule

// File: tb/tb_seq_subtractor_64bit.sv
// Self-checking bench for seq_subtractor_64bit against a plain-arithmetic reference.
module tb_seq_subtractor_64bit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [63:0] A = '0;
   logic [63:0] B = '0;
   logic [63:0] diff;
   logic        borrow, overflow, busy, done;

   int checks = 0;
   int failures = 0;

   seq_subtractor_64bit dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
      .diff(diff), .borrow(borrow), .overflow(overflow), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic ref_sub(input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] d, output logic bo, output logic ov);
      d  = a - b;
      bo = (a < b);
      ov = (a[63] != b[63]) && (d[63] != a[63]);
   endtask

   // Waits up to 20 edges (sampling #1 after each) for done; n = edges waited, -1 on timeout.
   task automatic wait_done(input string tag, output int n);
      n = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done) begin
            n = i;
            return;
         end
         chk({tag, ".busy"}, 64'(busy), 64'd1);
      end
   endtask

   task automatic check_result(input string tag, input logic [63:0] a, input logic [63:0] b);
      logic [63:0] d;
      logic bo, ov;
      ref_sub(a, b, d, bo, ov);
      chk({tag, ".diff"}, diff, d);
      chk({tag, ".borrow"}, 64'(borrow), 64'(bo));
      chk({tag, ".ovf"}, 64'(overflow), 64'(ov));
      chk({tag, ".busy_done"}, 64'(busy), 64'd0);
   endtask

   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b);
      int n;
      logic [63:0] d;
      logic bo, ov;
      ref_sub(a, b, d, bo, ov);
      @(negedge clk);
      A = a; B = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      A = {$urandom, $urandom};
      B = {$urandom, $urandom};
      chk({tag, ".acc_busy"}, 64'(busy), 64'd1);
      chk({tag, ".acc_done"}, 64'(done), 64'd0);
      wait_done(tag, n);
      chk({tag, ".latency"}, 64'(n), 64'd8);
      check_result(tag, a, b);
      @(posedge clk); #1;
      chk({tag, ".pulse"}, 64'(done), 64'd0);
      chk({tag, ".hold"}, diff, d);
   endtask

   initial begin
      int n;
      logic [63:0] a1, b1, a2, b2;

      #12;
      chk("rst.diff", diff, 64'd0);
      chk("rst.flags", {60'd0, borrow, overflow, busy, done}, 64'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("idle.flags", {60'd0, borrow, overflow, busy, done}, 64'd0);

      run_op("v1", 64'd923, 64'd534);
      run_op("v2", 64'd534, 64'd923);
      run_op("v3", 64'h8000000000000000, 64'd1);
      run_op("v4", 64'h0000000000000100, 64'd1);
      run_op("v5", 64'h7FFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
      run_op("v6", 64'd0, 64'd0);
      for (int i = 0; i < 20; i++)
         run_op("rnd", {$urandom, $urandom}, {$urandom, $urandom});

      // Start during RUN is ignored; start held through DONE is accepted.
      a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
      a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
      @(negedge clk);
      A = a1; B = b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      A = {$urandom, $urandom}; B = {$urandom, $urandom}; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("e3", n);
      chk("e3.latency", 64'(n), 64'd4);
      check_result("e3", a1, b1);
      A = a2; B = b2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      A = '0; B = '0;
      chk("b2b.busy", 64'(busy), 64'd1);
      chk("b2b.done", 64'(done), 64'd0);
      wait_done("b2b", n);
      chk("b2b.latency", 64'(n), 64'd8);
      check_result("b2b", a2, b2);

      // Asynchronous reset mid-run.
      @(negedge clk);
      A = 64'hFFFFFFFFFFFFFFFF; B = 64'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst.diff", diff, 64'd0);
      chk("arst.flags", {60'd0, borrow, overflow, busy, done}, 64'd0);
      @(negedge clk); rst = 1'b0;
      run_op("post", 64'd2, 64'd3);
      chk("post.diff", diff, 64'hFFFFFFFFFFFFFFFF);
      chk("post.borrow", 64'(borrow), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
